tdp_ram_be: RTL and testbench
=============================

# tdp_ram_be

Parametrised true dual-port synchronous RAM. It is the successor to the 64x16 shared-write dual-port RAM. Each port has its own enable, per-byte write enables and input data. The read mode (read-first, write-first, no-change) is selectable, an optional output pipeline register can be added, and a per-port read-valid flag and a same-address collision flag are provided. It serves as the general on-chip storage primitive for FIFOs, line buffers and register files that need two independent read/write agents.

## Interface
Parameters:
- DATA_W, 16, word width; must be a multiple of BYTE_W
- BYTE_W, 8, bits per byte lane; NB = DATA_W/BYTE_W
- ADDR_W, 6, address width; depth = 2**ADDR_W words
- READ_MODE, 0, 0 = read-first, 1 = write-first, 2 = no-change (applies to both ports)
- OUT_REG, 0, 1 adds an output pipeline stage to both ports

Ports (the x = 1/2 lines each stand for two ports, one per port):
- CLK  in  1  single clock; all logic on rising edge
- RST_N  in  1  synchronous active-low reset
- enx  in  1  port x access enable
- wex  in  NB  port x byte write enables; bit i covers di[i*BYTE_W +: BYTE_W]; ignored when enx=0
- addrx  in  ADDR_W  port x address
- dix  in  DATA_W  port x write data
- dox  out  DATA_W  port x read data
- validx  out  1  port x read data valid
- collision  out  1  registered same-address conflict flag

## Operation
- Access: an edge with enx=1 performs a port-x access at addrx. Each byte lane i with wex[i]=1 is written with dix lane i. Lanes with wex=0 keep their stored value.
- Read data: every enabled access produces a read beat, including write accesses except under no-change.
- Read data by mode (bytes not written always return stored data):
  - Read-first: dox is the word before the write.
  - Write-first: dox is the merged word after the write.
  - No-change: an access with any wex bit set produces no beat; dox holds and validx stays 0.
- Idle: when enx=0, dox holds its last value and validx=0.
- Same-address cycle (en1 = en2 = 1, addr1 = addr2):
  - Writes: for each byte lane written by both ports, port 1 wins. Lanes written by only one port take that port's data.
  - Cross-port reads: a port sees the other port's write as not yet happened; its read follows its own READ_MODE relative to its own write only.
  - collision: asserted when at least one port writes. It rises one cycle after the access edge (OUT_REG=0) or two cycles after (OUT_REG=1), aligned with the data, and lasts one cycle per colliding access.
  - Both ports reading the same address is not a collision.
- Reset (RST_N=0 sampled at an edge):
  - dox = 0, validx = 0, collision = 0, and all pipeline stages cleared.
  - Memory writes are suppressed during the reset edge, but memory contents are retained (no array clear).
  - Reads or writes issued at the reset edge are discarded. An in-flight beat in the OUT_REG stage is dropped.
- Memory content after power-up is undefined until written.

## Timing
- Latency from access edge to dox/validx update: 1 cycle with OUT_REG=0, 2 cycles with OUT_REG=1.
- Fully pipelined: one access per port per cycle, with no stalls or back-pressure.
- With OUT_REG=1, the second stage loads every cycle. Its valid equals the first-stage valid. Its data loads only when the first-stage valid is 1; otherwise the held data is kept.
- Back-to-back accesses to the same address on the same port: the second read returns the data written by the first.
- Port 1 write at address A in cycle n, then port 2 read of A in cycle n+1: the read returns the new data.
- First access after RST_N deasserts: accepted on the first edge with RST_N=1.
- Reset values of all outputs: dox = 0, validx = 0, collision = 0.

## Test plan
- Reset: hold RST_N=0 for 2 cycles with en1=1, we1=2'b11, addr1=5, di1=16'hDEAD. Then read addr 5 from both ports. Required: do/valid/collision = 0 during reset, and the read does not return 16'hDEAD.
- Byte write: write 16'h1234 at addr 3 with we1=2'b11, then write 16'hAB00 at addr 3 with we1=2'b10, then read addr 3 from port 2. Required: do2 = 16'hAB34, valid2 high exactly 1 cycle (2 cycles with OUT_REG=1) after the read edge.
- Read modes: addr 7 holds 16'h0001; port 1 writes 16'h00FF with we1=2'b11. Required:
  - READ_MODE=0: do1 = 16'h0001, valid1=1.
  - READ_MODE=1: do1 = 16'h00FF, valid1=1.
  - READ_MODE=2: valid1=0 and do1 holds its previous value; a later read returns 16'h00FF.
- Collision: with en1 = en2 = 1 at addr 9, port 1 writes 16'h1111 (we=2'b11) and port 2 writes 16'h2222 (we=2'b01). Required: mem[9] = 16'h1111, collision=1 for one cycle at the read latency. A simultaneous read of addr 9 on both ports with no writes leaves collision=0.
- Pipelined streaming: port 1 writes addr 0..63 with data = addr*3 on consecutive cycles, while port 2 reads addr 0..63 lagging by 1 cycle. Required: every do2 equals addr*3, with validx continuous and no bubbles, for both OUT_REG settings.
- Reset mid-stream with OUT_REG=1: assert RST_N=0 for 1 cycle while beats are in flight. Required: no valid beat emerges from accesses issued at or before the reset edge, and accesses after it resume with normal latency.

Source files
------------

// File: rtl/tdp_ram_be_if.sv
// tdp_ram_be_if
// Bundles both access ports and the collision flag of tdp_ram_be.
//   en1/en2      access enables
//   we1/we2      per-byte write enables (bit i covers lane i)
//   addr1/addr2  word addresses
//   di1/di2      write data
//   do1/do2      read data (held when no beat is produced)
//   valid1/2     read beat valid
//   collision    same-address conflict with at least one write, aligned with data
// master: the agent driving accesses; slave: the RAM.
interface tdp_ram_be_if #(
    parameter int DATA_W = 16,
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 6
);
    localparam int NB = DATA_W / BYTE_W;

    logic              en1;
    logic              en2;
    logic [NB-1:0]     we1;
    logic [NB-1:0]     we2;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] di1;
    logic [DATA_W-1:0] di2;
    logic [DATA_W-1:0] do1;
    logic [DATA_W-1:0] do2;
    logic              valid1;
    logic              valid2;
    logic              collision;

    modport master (
        output en1, en2, we1, we2, addr1, addr2, di1, di2,
        input  do1, do2, valid1, valid2, collision
    );

    modport slave (
        input  en1, en2, we1, we2, addr1, addr2, di1, di2,
        output do1, do2, valid1, valid2, collision
    );
endinterface

// File: rtl/tdp_ram_be.sv
// tdp_ram_be
// True dual-port synchronous RAM with per-byte write enables, selectable
// read mode (0 read-first, 1 write-first, 2 no-change), optional output
// register stage, per-port read-valid and a registered collision flag.
// Ports:
//   CLK    rising-edge clock
//   RST_N  synchronous active-low reset (outputs/pipeline cleared, memory kept)
//   bus    tdp_ram_be_if slave modport carrying both ports and collision
module tdp_ram_be #(
    parameter int DATA_W    = 16,
    parameter int BYTE_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int READ_MODE = 0,
    parameter int OUT_REG   = 0
) (
    input  logic         CLK,
    input  logic         RST_N,
    tdp_ram_be_if.slave  bus
);
    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    logic              beat1;
    logic              beat2;
    logic              coll_hit;
    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;
    logic              v1_reg;
    logic              v2_reg;
    logic              coll_reg;

    // Under no-change, any written lane suppresses the whole read beat.
    always_comb begin
        beat1    = bus.en1 && !((READ_MODE == 2) && (|bus.we1));
        beat2    = bus.en2 && !((READ_MODE == 2) && (|bus.we2));
        coll_hit = bus.en1 && bus.en2 && (bus.addr1 == bus.addr2)
                   && ((|bus.we1) || (|bus.we2));
    end

    // One narrow memory per byte lane so lane enables map onto plain writes.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [BYTE_W-1:0] mem [DEPTH];
            logic [BYTE_W-1:0] rd1_lane_reg;
            logic [BYTE_W-1:0] rd2_lane_reg;

            // Port 1 write is issued last so it wins a same-lane, same-address clash.
            always_ff @(posedge CLK) begin
                if (RST_N) begin
                    if (bus.en2 && bus.we2[gi])
                        mem[bus.addr2] <= bus.di2[gi*BYTE_W +: BYTE_W];
                    if (bus.en1 && bus.we1[gi])
                        mem[bus.addr1] <= bus.di1[gi*BYTE_W +: BYTE_W];
                end
            end

            // Reads see the pre-edge array, so the other port's write is not
            // yet visible; write-first only substitutes this port's own data.
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    rd1_lane_reg <= '0;
                    rd2_lane_reg <= '0;
                end else begin
                    if (beat1)
                        rd1_lane_reg <= ((READ_MODE == 1) && bus.we1[gi])
                                        ? bus.di1[gi*BYTE_W +: BYTE_W] : mem[bus.addr1];
                    if (beat2)
                        rd2_lane_reg <= ((READ_MODE == 1) && bus.we2[gi])
                                        ? bus.di2[gi*BYTE_W +: BYTE_W] : mem[bus.addr2];
                end
            end

            assign rd1_data[gi*BYTE_W +: BYTE_W] = rd1_lane_reg;
            assign rd2_data[gi*BYTE_W +: BYTE_W] = rd2_lane_reg;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            v1_reg   <= 1'b0;
            v2_reg   <= 1'b0;
            coll_reg <= 1'b0;
        end else begin
            v1_reg   <= beat1;
            v2_reg   <= beat2;
            coll_reg <= coll_hit;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] q1_reg;
            logic [DATA_W-1:0] q2_reg;
            logic              qv1_reg;
            logic              qv2_reg;
            logic              qcoll_reg;

            // Valid/collision advance every cycle; data only moves with a beat
            // so an idle cycle keeps the last delivered word on the output.
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    q1_reg    <= '0;
                    q2_reg    <= '0;
                    qv1_reg   <= 1'b0;
                    qv2_reg   <= 1'b0;
                    qcoll_reg <= 1'b0;
                end else begin
                    qv1_reg   <= v1_reg;
                    qv2_reg   <= v2_reg;
                    qcoll_reg <= coll_reg;
                    if (v1_reg)
                        q1_reg <= rd1_data;
                    if (v2_reg)
                        q2_reg <= rd2_data;
                end
            end

            assign bus.do1       = q1_reg;
            assign bus.do2       = q2_reg;
            assign bus.valid1    = qv1_reg;
            assign bus.valid2    = qv2_reg;
            assign bus.collision = qcoll_reg;
        end else begin : g_no_out_reg
            assign bus.do1       = rd1_data;
            assign bus.do2       = rd2_data;
            assign bus.valid1    = v1_reg;
            assign bus.valid2    = v2_reg;
            assign bus.collision = coll_reg;
        end
    endgenerate
endmodule

// File: tb/tb_tdp_ram_be.sv
// tb_tdp_ram_be
// Drives three RAM instances with identical stimulus:
//   u0: read-first,  no output register (latency 1)
//   u1: write-first, output register    (latency 2)
//   u2: no-change,   no output register (latency 1)
// Expected values are hand-computed constants per instance.
module tb_tdp_ram_be;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en1, en2;
    logic [1:0]  we1, we2;
    logic [5:0]  addr1, addr2;
    logic [15:0] di1, di2;

    int n_total = 0;
    int n_bad   = 0;

    tdp_ram_be_if #(.DATA_W(16), .BYTE_W(8), .ADDR_W(6)) b0 ();
    tdp_ram_be_if #(.DATA_W(16), .BYTE_W(8), .ADDR_W(6)) b1 ();
    tdp_ram_be_if #(.DATA_W(16), .BYTE_W(8), .ADDR_W(6)) b2 ();

    assign b0.en1 = en1;   assign b0.en2 = en2;   assign b0.we1 = we1;   assign b0.we2 = we2;
    assign b0.addr1 = addr1; assign b0.addr2 = addr2; assign b0.di1 = di1; assign b0.di2 = di2;
    assign b1.en1 = en1;   assign b1.en2 = en2;   assign b1.we1 = we1;   assign b1.we2 = we2;
    assign b1.addr1 = addr1; assign b1.addr2 = addr2; assign b1.di1 = di1; assign b1.di2 = di2;
    assign b2.en1 = en1;   assign b2.en2 = en2;   assign b2.we1 = we1;   assign b2.we2 = we2;
    assign b2.addr1 = addr1; assign b2.addr2 = addr2; assign b2.di1 = di1; assign b2.di2 = di2;

    tdp_ram_be #(.DATA_W(16), .BYTE_W(8), .ADDR_W(6), .READ_MODE(0), .OUT_REG(0))
        u0 (.CLK(clk), .RST_N(rst_n), .bus(b0));
    tdp_ram_be #(.DATA_W(16), .BYTE_W(8), .ADDR_W(6), .READ_MODE(1), .OUT_REG(1))
        u1 (.CLK(clk), .RST_N(rst_n), .bus(b1));
    tdp_ram_be #(.DATA_W(16), .BYTE_W(8), .ADDR_W(6), .READ_MODE(2), .OUT_REG(0))
        u2 (.CLK(clk), .RST_N(rst_n), .bus(b2));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then park on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        en1 = 1'b0; en2 = 1'b0; we1 = 2'b00; we2 = 2'b00;
    endtask

    task automatic acc(input logic e1, input logic [1:0] w1, input logic [5:0] a1, input logic [15:0] d1,
                       input logic e2, input logic [1:0] w2, input logic [5:0] a2, input logic [15:0] d2);
        en1 = e1; we1 = w1; addr1 = a1; di1 = d1;
        en2 = e2; we2 = w2; addr2 = a2; di2 = d2;
        $display("acc p1 en=%0b we=%b a=%0d d=%h | p2 en=%0b we=%b a=%0d d=%h",
                 e1, w1, a1, d1, e2, w2, a2, d2);
        step();
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        addr1 = '0; addr2 = '0; di1 = '0; di2 = '0;
        step();
        rst_n = 1'b1;

        // Known contents at addr 5, then a reset with a write attempt on top.
        acc(1'b1, 2'b11, 6'd5, 16'h5555, 1'b0, 2'b00, 6'd0, 16'h0);
        step(); step();
        rst_n = 1'b0;
        en1 = 1'b1; we1 = 2'b11; addr1 = 6'd5; di1 = 16'hDEAD;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("u0 reset outs", {b0.do1, b0.do2, b0.valid1, b0.valid2, b0.collision}, 64'd0);
            chk("u1 reset outs", {b1.do1, b1.do2, b1.valid1, b1.valid2, b1.collision}, 64'd0);
            chk("u2 reset outs", {b2.do1, b2.do2, b2.valid1, b2.valid2, b2.collision}, 64'd0);
        end
        rst_n = 1'b1;
        idle();

        // Read addr 5 from both ports on the first edge out of reset.
        acc(1'b1, 2'b00, 6'd5, 16'h0, 1'b1, 2'b00, 6'd5, 16'h0);
        chk("u0 rst rd do1", b0.do1, 16'h5555);
        chk("u0 rst rd v1", b0.valid1, 1'b1);
        chk("u0 rst rd do2", b0.do2, 16'h5555);
        chk("u0 rd-rd coll", b0.collision, 1'b0);
        chk("u2 rst rd do1", b2.do1, 16'h5555);
        chk("u1 lat2 v1 early", b1.valid1, 1'b0);
        chk("u1 lat2 do1 early", b1.do1, 16'h0);
        step();
        chk("u1 rst rd do1", b1.do1, 16'h5555);
        chk("u1 rst rd v1", b1.valid1, 1'b1);
        chk("u1 rst rd do2", b1.do2, 16'h5555);
        chk("u1 rd-rd coll", b1.collision, 1'b0);
        chk("u0 v1 drop", b0.valid1, 1'b0);
        chk("u0 do1 hold", b0.do1, 16'h5555);

        // Byte-lane write merge.
        acc(1'b1, 2'b11, 6'd3, 16'h1234, 1'b0, 2'b00, 6'd0, 16'h0);
        acc(1'b1, 2'b10, 6'd3, 16'hAB00, 1'b0, 2'b00, 6'd0, 16'h0);
        acc(1'b0, 2'b00, 6'd0, 16'h0, 1'b1, 2'b00, 6'd3, 16'h0);
        chk("u0 byte do2", b0.do2, 16'hAB34);
        chk("u0 byte v2", b0.valid2, 1'b1);
        chk("u1 byte v2 early", b1.valid2, 1'b0);
        step();
        chk("u1 byte do2", b1.do2, 16'hAB34);
        chk("u1 byte v2", b1.valid2, 1'b1);
        chk("u0 byte v2 drop", b0.valid2, 1'b0);

        // Read modes: addr 7 holds 0001, port 1 writes 00FF.
        acc(1'b1, 2'b11, 6'd7, 16'h0001, 1'b0, 2'b00, 6'd0, 16'h0);
        step(); step();
        acc(1'b1, 2'b11, 6'd7, 16'h00FF, 1'b0, 2'b00, 6'd0, 16'h0);
        chk("u0 rfirst do1", b0.do1, 16'h0001);
        chk("u0 rfirst v1", b0.valid1, 1'b1);
        chk("u2 nochg v1", b2.valid1, 1'b0);
        chk("u2 nochg do1 hold", b2.do1, 16'h5555);
        step();
        chk("u1 wfirst do1", b1.do1, 16'h00FF);
        chk("u1 wfirst v1", b1.valid1, 1'b1);
        acc(1'b1, 2'b00, 6'd7, 16'h0, 1'b0, 2'b00, 6'd0, 16'h0);
        chk("u2 later rd do1", b2.do1, 16'h00FF);
        chk("u2 later rd v1", b2.valid1, 1'b1);
        chk("u0 later rd do1", b0.do1, 16'h00FF);

        // Same-address collision with overlapping low lane.
        acc(1'b1, 2'b11, 6'd9, 16'h1111, 1'b1, 2'b01, 6'd9, 16'h2222);
        chk("u0 coll rise", b0.collision, 1'b1);
        chk("u2 coll rise", b2.collision, 1'b1);
        chk("u1 coll early", b1.collision, 1'b0);
        step();
        chk("u0 coll fall", b0.collision, 1'b0);
        chk("u1 coll rise", b1.collision, 1'b1);
        step();
        chk("u1 coll fall", b1.collision, 1'b0);
        acc(1'b1, 2'b00, 6'd9, 16'h0, 1'b1, 2'b00, 6'd9, 16'h0);
        chk("u0 coll mem p1", b0.do1, 16'h1111);
        chk("u0 coll mem p2", b0.do2, 16'h1111);
        chk("u0 rd-rd no coll", b0.collision, 1'b0);
        step();
        chk("u1 coll mem p2", b1.do2, 16'h1111);
        chk("u1 rd-rd no coll", b1.collision, 1'b0);

        // Streaming: port 1 writes addr*3, port 2 reads one cycle behind.
        for (int k = 0; k < 66; k++) begin
            en1 = (k < 64); we1 = (k < 64) ? 2'b11 : 2'b00;
            addr1 = 6'(k); di1 = 16'(k * 3);
            en2 = (k >= 1 && k <= 64); addr2 = 6'(k - 1);
            $display("stream k=%0d wr a=%0d d=%h rd a=%0d en2=%0b", k, addr1, di1, addr2, en2);
            step();
            if (k >= 1 && k <= 64) begin
                chk("u0 stream v2", b0.valid2, 1'b1);
                chk("u0 stream do2", b0.do2, 64'((k - 1) * 3));
            end
            if (k >= 2) begin
                chk("u1 stream v2", b1.valid2, 1'b1);
                chk("u1 stream do2", b1.do2, 64'((k - 2) * 3));
            end
        end
        idle();

        // Reset mid-stream: reads of addr 10..14 on port 2, reset at the third edge.
        en2 = 1'b1; addr2 = 6'd10;
        step();
        chk("u1 mid v2 e0", b1.valid2, 1'b0);
        addr2 = 6'd11;
        step();
        chk("u1 mid do2 e1", b1.do2, 16'd30);
        chk("u1 mid v2 e1", b1.valid2, 1'b1);
        chk("u0 mid do2 e1", b0.do2, 16'd33);
        rst_n = 1'b0; addr2 = 6'd12;
        step();
        chk("u1 mid rst outs", {b1.do2, b1.valid2}, 64'd0);
        chk("u0 mid rst outs", {b0.do2, b0.valid2}, 64'd0);
        rst_n = 1'b1; addr2 = 6'd13;
        step();
        chk("u1 mid v2 e3", b1.valid2, 1'b0);
        chk("u0 mid do2 e3", b0.do2, 16'd39);
        chk("u0 mid v2 e3", b0.valid2, 1'b1);
        addr2 = 6'd14;
        step();
        chk("u1 mid do2 e4", b1.do2, 16'd39);
        chk("u1 mid v2 e4", b1.valid2, 1'b1);
        idle();
        step();
        chk("u1 mid do2 e5", b1.do2, 16'd42);
        chk("u1 mid v2 e5", b1.valid2, 1'b1);
        step();
        chk("u1 mid v2 e6", b1.valid2, 1'b0);
        chk("u1 mid do2 hold", b1.do2, 16'd42);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
